systolic_row_feeder: RTL
========================

Name: systolic_row_feeder

Overview:
- Upstream stage of the fp16 systolic MAC array. Accepts A-matrix tiles one K-column per beat over a valid/ready handshake and holds them in a ping-pong buffer.
- Streams each tile into the array's left edge with diagonal skew: row r is delayed r cycles and padded with fp16 zero (16'h0000), so every PE sees correctly aligned data/weight pairs.
- The second bank loads while the first streams, so back-to-back tiles leave no bubble.

Parameters:
ROWS, 4, array rows = number of output lanes
DEPTH, 4, K-dimension columns per tile
DW, 16, element width (fp16)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input column beat valid
in_ready  out  1  feeder can accept a beat
in_data  in  ROWS*DW  column k of tile; lane r = bits [r*DW +: DW] = A[r][k]
out_valid  out  1  skewed output beat valid
out_data  out  ROWS*DW  lane r feeds inp_data of array row r
tile_done  out  1  one-cycle pulse on last output beat of a tile
busy  out  1  stream FSM not IDLE

Behaviour:
- Reset (async, high): all outputs 0 (in_ready=0, out_valid=0, out_data=0, tile_done=0, busy=0); both banks EMPTY; wr_bank=rd_bank=0; counters 0. Reset mid-load or mid-stream discards all buffered data. First cycle after reset release: in_ready=1.
- Storage: 2 banks x ROWS x DEPTH x DW. Per-bank status register: EMPTY / FULL (a bank is FULL from last-beat accept until its stream's last beat).
- Write side:
  - in_ready = (status[wr_bank]==EMPTY), registered-status based.
  - Accept = in_valid & in_ready; writes in_data to column wr_cnt of wr_bank.
  - Accept with wr_cnt==DEPTH-1: status[wr_bank]<=FULL, wr_bank toggles, wr_cnt<=0; otherwise wr_cnt++.
  - in_data is ignored when not accepted; a dropped in_valid holds wr_cnt.
- Read FSM, states IDLE and STREAM; t counts 0..L-1, where L = DEPTH+ROWS-1:
  - IDLE, status[rd_bank]==FULL: go to STREAM; the same edge loads beat t=0 into the output registers and sets out_valid=1. out_valid therefore rises exactly one cycle after the edge that accepted a tile's last beat, when the feeder was IDLE.
  - STREAM beat t, lane r: out_data = A[rd_bank][r][t-r] if 0 <= t-r < DEPTH, else 16'h0000.
  - Beat t=L-1: tile_done=1 with that beat; status[rd_bank]<=EMPTY; rd_bank toggles.
  - After beat L-1, other bank FULL: stay in STREAM and present t=0 of the next tile on the next cycle (no gap). Otherwise go to IDLE: out_valid=0, out_data=0.
- No output backpressure: the array consumes every cycle.
- Simultaneous events:
  - A bank freed at beat L-1 shows in_ready=1 from the following cycle, not combinationally.
  - The writer filling the other bank during STREAM is independent.
- busy = (state==STREAM).
- Counter widths: $clog2 of DEPTH and L, min 1 bit. No arithmetic on data; pure move and zero-insert.
- No X on outputs at any time after reset.

Test Plan (ROWS=4, DEPTH=4, L=7):
- Reset values: assert reset mid-stream -> same cycle out_valid=0, out_data=0, tile_done=0, busy=0. After release -> in_ready=1, and a fresh tile streams correctly.
- Single tile: A[r][k]=16'h3C00+16*r+k, 4 contiguous beats -> out_valid high 7 cycles starting one cycle after 4th accept.
  - Lane0 = 3C00,3C01,3C02,3C03,0,0,0.
  - Lane3 = 0,0,0,3C30,3C31,3C32,3C33.
  - tile_done only on beat 6.
- Back-to-back: second tile loaded during first stream -> 14 consecutive out_valid cycles, no gap, tile_done on beats 6 and 13, second tile's t=0 directly after first's t=6.
- Backpressure to source: send 3 tiles continuously -> after banks 0/1 fill, in_ready=0 until first tile's beat 6; in_ready=1 the cycle after; third tile data streams intact.
- Gappy input: in_valid toggles 1,0,1,0... -> wr_cnt advances only on accepts; output identical to single-tile case; out_valid starts one cycle after final accept.
- Reset mid-load: 2 of 4 beats accepted, then reset -> no out_valid ever. A subsequent full tile streams its own data only, with no leftover beats.

Source files
------------

// File: rtl/systolic_row_feeder_if.sv
// Handshake bundle between the A-tile source, the row feeder and the array's left edge.
// The master side loads tiles and watches the skewed output. The slave side is the feeder.
interface systolic_row_feeder_if #(
    parameter int ROWS = 4,
    parameter int DW   = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   in_data;
    logic                 out_valid;
    logic [ROWS*DW-1:0]   out_data;
    logic                 tile_done;
    logic                 busy;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  tile_done,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output tile_done,
        output busy
    );
endinterface

// File: rtl/systolic_row_feeder.sv
// Ping-pong A-tile buffer feeding the left edge of the fp16 systolic array.
// Each tile arrives one K-column per beat. It leaves with row r delayed r cycles,
// and the unused slots are padded with fp16 zero. One bank loads while the other streams.
module systolic_row_feeder #(
    parameter int ROWS  = 4,
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    systolic_row_feeder_if.slave bus
);
    localparam int L  = DEPTH + ROWS - 1;
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (L > 1) ? $clog2(L) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic {IDLE, STREAM} state_t;
    typedef enum logic {EMPTY, FULL} bank_status_t;

    logic [DW-1:0]      mem [2][ROWS][DEPTH];
    bank_status_t       status [2];

    logic               wr_bank;
    logic [CW-1:0]      wr_cnt;
    logic               accept;

    state_t             state, state_next;
    logic [TW-1:0]      t, t_next;
    logic               rd_bank, rd_bank_next;
    logic               release_bank;

    logic               out_valid_q, out_valid_next;
    logic               tile_done_q, tile_done_next;
    logic [ROWS*DW-1:0] out_data_q, out_data_next;

    // Builds skewed beat 'beat' of a bank. Lane r carries column beat-r when that column exists, and zero otherwise.
    function automatic logic [ROWS*DW-1:0] skew_beat(input logic bank, input logic [TW-1:0] beat);
        logic [ROWS*DW-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
            int k;
            k = int'(beat) - r;
            if (k >= 0 && k < DEPTH) begin
                v[r*DW +: DW] = mem[bank][r[RW-1:0]][k[CW-1:0]];
            end
        end
        return v;
    endfunction

    // Readiness comes only from the registered bank status. A freed bank opens on the cycle after its last beat.
    assign bus.in_ready  = !reset && (status[wr_bank] == EMPTY);
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.tile_done = tile_done_q;
    assign bus.busy      = (state == STREAM);

    // Tile storage. Contents need no reset because a bank is only read after it has been written in full.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < ROWS; r++) begin
                mem[wr_bank][r[RW-1:0]][wr_cnt] <= bus.in_data[r*DW +: DW];
            end
        end
    end

    // Write pointer and bank status. The writer marks a bank full, and the streamer frees it after the last beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank   <= 1'b0;
            wr_cnt    <= '0;
            status[0] <= EMPTY;
            status[1] <= EMPTY;
        end else begin
            if (accept) begin
                if (wr_cnt == CW'(DEPTH - 1)) begin
                    status[wr_bank] <= FULL;
                    wr_bank         <= ~wr_bank;
                    wr_cnt          <= '0;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (release_bank) begin
                status[rd_bank] <= EMPTY;
            end
        end
    end

    // Stream sequencing. This block decides the next beat and chains straight into the other bank when it is already full.
    always_comb begin
        state_next     = state;
        t_next         = t;
        rd_bank_next   = rd_bank;
        release_bank   = 1'b0;
        out_valid_next = 1'b0;
        out_data_next  = '0;
        case (state)
            IDLE: begin
                if (status[rd_bank] == FULL) begin
                    state_next     = STREAM;
                    t_next         = '0;
                    out_valid_next = 1'b1;
                    out_data_next  = skew_beat(rd_bank, '0);
                end
            end
            STREAM: begin
                if (t == TW'(L - 1)) begin
                    release_bank = 1'b1;
                    rd_bank_next = ~rd_bank;
                    if (status[~rd_bank] == FULL) begin
                        t_next         = '0;
                        out_valid_next = 1'b1;
                        out_data_next  = skew_beat(~rd_bank, '0);
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    t_next         = t + 1'b1;
                    out_valid_next = 1'b1;
                    out_data_next  = skew_beat(rd_bank, t + 1'b1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        tile_done_next = out_valid_next && (t_next == TW'(L - 1));
    end

    // Stream state and registered outputs. The edge that enters STREAM already presents beat 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            t           <= '0;
            rd_bank     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            tile_done_q <= 1'b0;
        end else begin
            state       <= state_next;
            t           <= t_next;
            rd_bank     <= rd_bank_next;
            out_valid_q <= out_valid_next;
            out_data_q  <= out_data_next;
            tile_done_q <= tile_done_next;
        end
    end
endmodule
